alu_iter_unit: RTL and testbench
================================

Name: alu_iter_unit

Overview:
- Parametrised, sequential successor to the ALU's combinational AND/shift/increment datapath cells.
- Captures operands on a start handshake and executes one of four ops: AND, INC, multi-position SHR or serial ADD.
- Holds the result plus carry/zero flags in registers and signals completion with a one-cycle done pulse.
- Sits between the register file read ports and the writeback mux.

Parameters:
- WIDTH, 20, datapath width in bits (minimum 2).
- SHW, $clog2(WIDTH+1), width of the shift-amount port.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- op  input  3  0=AND, 1=INC, 2=SHR, 3=ADD, 4..7 reserved.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (AND, ADD only).
- shamt  input  SHW  SHR position count.
- busy  output  1  high while an op is executing.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  registered result.
- carry  output  1  registered carry flag.
- zero  output  1  registered flag: 1 iff result is all zeros.
- err  output  1  registered flag: 1 iff the last op code was reserved.

Behaviour:
- Bit order (ALU-wide): index WIDTH-1 is least significant, index 0 most significant. Carries propagate from WIDTH-1 toward 0.
- Reset (async, rst_n=0): FSM returns to IDLE immediately, including mid-op. All outputs go to 0 except zero, which goes to 1. Any partial work is discarded.
- FSM states: IDLE, EXEC, FIN.
  - IDLE: start=1 at edge E0 captures a, b, op and shamt (clamped to WIDTH if larger), then enters EXEC. busy=1 from E0.
  - EXEC: runs for L edges. Exit to FIN at edge E0+L.
  - FIN: lasts one cycle with done=1 and busy=0, then returns to IDLE.
- start rules:
  - start in FIN is accepted, like IDLE: done pulses and the new op begins on the same edge.
  - start while busy=1 is ignored and not queued.
  - Input changes after E0 have no effect.
- Latency L by op:
  - AND=1
  - INC=1
  - reserved=1
  - SHR=max(shamt_clamped,1)
  - ADD=WIDTH (one bit per cycle)
- result, carry, zero and err update only at completion (edge E0+L) and hold until the next completion or reset.
- AND: result[i]=a[i]&b[i]; carry=0.
- INC: result=a+1 in the bit order above; carry=1 iff a is all ones (result wraps to 0).
- SHR, one position per EXEC cycle:
  - Each step: next[i]=cur[i-1] for i≥1; next[0]=0; carry=cur[WIDTH-1] (the bit shifted out).
  - shamt=0: result=a, carry=0, L=1.
  - shamt≥WIDTH: result=0, carry=original a[0].
- ADD, serial ripple:
  - Cycle k (k=0..WIDTH-1) processes index WIDTH-1-k with carry-in 0 at k=0.
  - Final carry-out from index 0 becomes carry; the sum is modulo 2^WIDTH.
- Reserved op: result=0, carry=0, zero=1, err=1.
- err is cleared to 0 by any valid completion.
- zero is always computed from the final registered result.

Test Plan:
- Reset: rst_n low mid-ADD (cycle 7 of 20) → busy=0, done=0, result=0, carry=0, zero=1 immediately. After release, start AND completes normally.
- AND: a=all ones, b=alternating 1010..., op=0 → one cycle after start, done=1 and result=1010...; carry=0, zero=0. Repeat with b=0 → zero=1.
- INC wrap: a=all ones, op=1 → result=0, carry=1, zero=1, L=1.
- INC LSB: a=0 → result has only bit 19 set, carry=0, zero=0.
- SHR: a has only bit 17 set, shamt=2, op=2 → done two cycles after start, result has only bit 19 set, carry=0.
- SHR flush: same a with shamt=3 → result=0, carry=1, zero=1.
- SHR clamp: shamt=31 with a[0]=1 → result=0, carry=1, L=20.
- ADD: a=b=only bit 19 set, op=3 → done exactly 20 cycles after start, result only bit 18 set, carry=0.
- ADD overflow: a=all ones, b=only bit 19 set → result=0, carry=1, zero=1.
- Handshake and reserved op: start held high during a 20-cycle ADD → only one op is executed. op=5 → L=1, err=1, zero=1; a following INC clears err.

Source files
------------

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_unit
//  Description : Sequential ALU iteration unit. Captures operands on a start
//                handshake and runs one of AND, INC, multi-position SHR or
//                bit-serial ADD, then publishes result/carry/zero/err flags
//                with a one-cycle done pulse.
//
//  Bit order   : index WIDTH-1 is the least significant bit, index 0 the
//                most significant. Carries move from WIDTH-1 toward 0.
//
//  Ports       : clk     - rising-edge clock
//                rst_n   - asynchronous active-low reset
//                start   - request, sampled whenever not busy (IDLE or FIN)
//                op      - 0=AND 1=INC 2=SHR 3=ADD 4..7 reserved
//                a, b    - operands (b used by AND and ADD only)
//                shamt   - SHR position count (clamped to WIDTH)
//                busy    - high while an op is executing
//                done    - one-cycle completion pulse
//                result  - registered result
//                carry   - registered carry flag
//                zero    - registered flag, 1 iff result is all zeros
//                err     - registered flag, 1 iff the last op was reserved
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit #(
    parameter int WIDTH = 20,
    parameter int SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int             IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0]     c_OP_AND    = 3'd0;
    localparam logic [2:0]     c_OP_INC    = 3'd1;
    localparam logic [2:0]     c_OP_SHR    = 3'd2;
    localparam logic [2:0]     c_OP_ADD    = 3'd3;
    localparam logic [SHW-1:0] c_SH_MAX    = SHW'(WIDTH);
    localparam logic [SHW-1:0] c_ADD_CNT   = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Bit reversal maps the ALU's MSB-at-index-0 order onto ordinary
    // arithmetic so the single-cycle increment can use a plain adder.
    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = x[WIDTH-1-i];
        end
        return y;
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_work;    // operand A, then shifted value / partial sum
    logic [WIDTH-1:0] r_b;
    logic             r_sh_en;   // SHR with a non-zero clamped count
    logic [SHW-1:0]   r_cnt;     // EXEC cycles remaining after this one
    logic             r_c;       // running carry (ADD) / last bit out (SHR)

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_err;

    logic             w_accept;
    logic             w_last;
    logic [SHW-1:0]   w_sh_clamp;
    logic [SHW-1:0]   w_cnt_init;
    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_work_nxt;
    logic             w_c_nxt;
    logic             w_a_bit;
    logic             w_b_bit;
    logic [WIDTH-1:0] w_inc_rev;
    logic [WIDTH-1:0] w_res;
    logic             w_car;
    logic             w_err;

    // FIN counts as not busy, so a request there starts the next op on the
    // same edge that ends the done pulse.
    assign w_accept   = start && (r_state != S_EXEC);
    assign w_last     = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_sh_clamp = (shamt > c_SH_MAX) ? c_SH_MAX : shamt;
    assign w_idx      = r_cnt[IW-1:0];

    // The remaining-cycle counter doubles as the ADD bit index: cycle k sees
    // r_cnt = WIDTH-1-k, which is exactly the index processed at that step.
    always_comb begin
        w_cnt_init = '0;
        case (op)
            c_OP_SHR: w_cnt_init = (w_sh_clamp == '0) ? '0 : (w_sh_clamp - 1'b1);
            c_OP_ADD: w_cnt_init = c_ADD_CNT;
            default:  w_cnt_init = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = start ? S_EXEC : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // One iteration step for the serial ops
    // ------------------------------------------------------------------------
    always_comb begin
        w_work_nxt = r_work;
        w_c_nxt    = r_c;
        w_a_bit    = r_work[w_idx];
        w_b_bit    = r_b[w_idx];
        case (r_op)
            c_OP_SHR: begin
                if (r_sh_en) begin
                    // Move every bit one place toward the LSB end; the bit
                    // at WIDTH-1 falls out and becomes the carry.
                    w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
                    w_c_nxt    = r_work[WIDTH-1];
                end
            end
            c_OP_ADD: begin
                // Sum bit overwrites the A bit it consumed; A is not needed
                // at that index afterwards.
                w_work_nxt[w_idx] = w_a_bit ^ w_b_bit ^ r_c;
                w_c_nxt           = (w_a_bit & w_b_bit) | (r_c & (w_a_bit ^ w_b_bit));
            end
            default: begin
                w_work_nxt = r_work;
                w_c_nxt    = r_c;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Values published on the final EXEC edge
    // ------------------------------------------------------------------------
    assign w_inc_rev = f_rev(r_work) + c_ONE;

    always_comb begin
        w_res = '0;
        w_car = 1'b0;
        w_err = 1'b0;
        case (r_op)
            c_OP_AND: begin
                w_res = r_work & r_b;
            end
            c_OP_INC: begin
                w_res = f_rev(w_inc_rev);
                w_car = &r_work;
            end
            c_OP_SHR, c_OP_ADD: begin
                w_res = w_work_nxt;
                w_car = w_c_nxt;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_work   <= '0;
            r_b      <= '0;
            r_sh_en  <= 1'b0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= op;
                r_work  <= a;
                r_b     <= b;
                r_sh_en <= (w_sh_clamp != '0);
                r_cnt   <= w_cnt_init;
                r_c     <= 1'b0;
            end else if (r_state == S_EXEC) begin
                r_work <= w_work_nxt;
                r_c    <= w_c_nxt;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            if (w_last) begin
                r_result <= w_res;
                r_carry  <= w_car;
                r_zero   <= (w_res == '0);
                r_err    <= w_err;
            end
        end
    end

    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_iter_unit
//  Description : Directed, table-driven bench for alu_iter_unit (WIDTH=20)
//                plus hand-written sequences for reset, handshake and
//                back-to-back corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iter_unit;

    localparam int W  = 20;
    localparam int SW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic          err;

    int n_cmp;
    int n_fail;

    alu_iter_unit #(
        .WIDTH (W),
        .SHW   (SW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [SW-1:0] sh;
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vq[$];

    function automatic void addv(string nm, logic [2:0] o, logic [W-1:0] va,
                                 logic [W-1:0] vb, logic [SW-1:0] s,
                                 logic [W-1:0] r, logic c, logic z, logic e,
                                 int l);
        vec_t v;
        v.name = nm; v.op = o; v.a = va; v.b = vb; v.sh = s;
        v.res = r; v.c = c; v.z = z; v.e = e; v.lat = l;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one op, scramble the inputs right after capture, then count
    // cycles until done is seen (bounded).
    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic [SW-1:0] sh,
                          output int lat);
        @(negedge clk);
        op = o; a = ia; b = ib; shamt = sh; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ia; b = ~ib; shamt = ~sh; op = 3'd7;
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 200);
    endtask

    task automatic chk_out(input string nm, input logic [W-1:0] r, input logic c,
                           input logic z, input logic e);
        chk({nm, ".result"}, 32'(result), 32'(r));
        chk({nm, ".carry"},  32'(carry),  32'(c));
        chk({nm, ".zero"},   32'(zero),   32'(z));
        chk({nm, ".err"},    32'(err),    32'(e));
    endtask

    initial begin
        int lat;
        n_cmp  = 0;
        n_fail = 0;
        start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
        rst_n = 1'b0;

        //      name         op    a          b          sh     result     c  z  e  L
        addv("and_alt",    3'd0, 20'hFFFFF, 20'hAAAAA, 5'd0,  20'hAAAAA, 0, 0, 0, 1);
        addv("and_zero",   3'd0, 20'hFFFFF, 20'h00000, 5'd0,  20'h00000, 0, 1, 0, 1);
        addv("inc_wrap",   3'd1, 20'hFFFFF, 20'h00000, 5'd0,  20'h00000, 1, 1, 0, 1);
        addv("inc_lsb",    3'd1, 20'h00000, 20'h00000, 5'd0,  20'h80000, 0, 0, 0, 1);
        addv("inc_ripple", 3'd1, 20'hC0000, 20'h00000, 5'd0,  20'h20000, 0, 0, 0, 1);
        addv("shr_2",      3'd2, 20'h20000, 20'h00000, 5'd2,  20'h80000, 0, 0, 0, 2);
        addv("shr_flush",  3'd2, 20'h20000, 20'h00000, 5'd3,  20'h00000, 1, 1, 0, 3);
        addv("shr_zero",   3'd2, 20'h12345, 20'h00000, 5'd0,  20'h12345, 0, 0, 0, 1);
        addv("shr_one",    3'd2, 20'h80000, 20'h00000, 5'd1,  20'h00000, 1, 1, 0, 1);
        addv("shr_clamp",  3'd2, 20'h00001, 20'h00000, 5'd31, 20'h00000, 1, 1, 0, 20);
        addv("add_lsb",    3'd3, 20'h80000, 20'h80000, 5'd0,  20'h40000, 0, 0, 0, 20);
        addv("add_ovf",    3'd3, 20'hFFFFF, 20'h80000, 5'd0,  20'h00000, 1, 1, 0, 20);
        addv("add_3p1",    3'd3, 20'hC0000, 20'h80000, 5'd0,  20'h20000, 0, 0, 0, 20);
        addv("add_msb",    3'd3, 20'h00001, 20'h00001, 5'd0,  20'h00000, 1, 1, 0, 20);
        addv("rsv_op5",    3'd5, 20'h12345, 20'h54321, 5'd4,  20'h00000, 0, 1, 1, 1);
        addv("inc_clr",    3'd1, 20'h00000, 20'h00000, 5'd0,  20'h80000, 0, 0, 0, 1);

        // Reset state
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_out("rst", 20'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            run_op(vq[i].name, vq[i].op, vq[i].a, vq[i].b, vq[i].sh, lat);
            chk({vq[i].name, ".latency"}, 32'(lat), 32'(vq[i].lat));
            chk_out(vq[i].name, vq[i].res, vq[i].c, vq[i].z, vq[i].e);
            @(posedge clk);
            #1;
            chk({vq[i].name, ".done_pulse"}, 32'(done), 32'd0);
            chk({vq[i].name, ".hold"}, 32'(result), 32'(vq[i].res));
        end

        // Asynchronous reset in cycle 7 of a 20-cycle ADD
        @(negedge clk);
        op = 3'd3; a = 20'hFFFFF; b = 20'h80000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk_out("midrst", 20'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_and", 3'd0, 20'hFFFFF, 20'h12345, 5'd0, lat);
        chk("post_rst_and.latency", 32'(lat), 32'd1);
        chk_out("post_rst_and", 20'h12345, 1'b0, 1'b0, 1'b0);

        // start held high through an ADD: exactly one op executes
        @(negedge clk);
        op = 3'd3; a = 20'h80000; b = 20'h80000; start = 1'b1;
        @(posedge clk);
        #1 a = 20'hFFFFF; b = 20'hFFFFF;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 200);
        start = 1'b0;
        chk("held.latency", 32'(lat), 32'd20);
        chk_out("held", 20'h40000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("held.no_requeue_busy", 32'(busy), 32'd0);
        chk("held.no_requeue_done", 32'(done), 32'd0);

        // start during FIN: accepted on the edge that ends done
        run_op("b2b_first", 3'd0, 20'hFFFFF, 20'h0F0F0, 5'd0, lat);
        chk_out("b2b_first", 20'h0F0F0, 1'b0, 1'b0, 1'b0);
        op = 3'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b.done2", 32'(done), 32'd1);
        chk_out("b2b_second", 20'h0, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
